// File: rtl/digitube_if.sv
// Digit-tube driver bus: scan control/data in, 12-bit scanning bus and frame strobe out.
interface digitube_if;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [11:0] digi_out;
  logic        frame_done;

  modport master (output en, value, dp_in, blank_in, input digi_out, frame_done);
  modport slave  (input en, value, dp_in, blank_in, output digi_out, frame_done);
endinterface

// File: rtl/digitube_driver.sv
// Four-digit hex scanner: blanking gap before each digit, inputs sampled once per frame.
module digitube_driver #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  digitube_if.slave  bus
);
  localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : ((BLANK_CYCLES > 1) ? BLANK_CYCLES : 1);
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {BLANK, SHOW} state_t;
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } snap_t;

  state_t        state, state_d;
  logic [1:0]    idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  snap_t         snap, snap_d;
  logic [11:0]   digi_q, digi_d;
  logic          frame_q, frame_d;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt + 1'b1;
    snap_d  = snap;
    frame_d = 1'b0;
    if (!bus.en) begin
      state_d = BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state == BLANK) begin
      if (cnt == BLANK_LAST) begin
        state_d = SHOW;
        cnt_d   = '0;
      end
    end else if (cnt == SHOW_LAST) begin
      idx_d   = idx + 2'd1;
      cnt_d   = '0;
      frame_d = (idx == 2'd3);
      state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
    end
    // Sample on the edge that starts digit 0 so all four digits come from one value.
    if (bus.en && state_d == SHOW && idx_d == 2'd0 && (state == BLANK || cnt == SHOW_LAST))
      snap_d = '{value: bus.value, dp: bus.dp_in, blank: bus.blank_in};
    // Output is registered from next-state so it lines up with the state it describes.
    digi_d = 12'h0FF;
    if (state_d == SHOW && !snap_d.blank[idx_d])
      digi_d = {4'b0001 << idx_d, ~snap_d.dp[idx_d], hex7(snap_d.value[{idx_d, 2'b00} +: 4])};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= BLANK;
      idx     <= '0;
      cnt     <= '0;
      snap    <= '0;
      digi_q  <= 12'h0FF;
      frame_q <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cnt     <= cnt_d;
      snap    <= snap_d;
      digi_q  <= digi_d;
      frame_q <= frame_d;
    end
  end

  assign bus.digi_out   = digi_q;
  assign bus.frame_done = frame_q;
endmodule
